// File: rtl/blc_sched.sv
// Round-robin scheduler sharing one Binary-Logarithmic Converter among NUM_REQ requesters.
// Two-stage pipeline (arbitrate/leading-one, then capture BLC result) with full backpressure.
module blc_sched #(
  parameter int LOG2_WIDTH = 4,
  parameter int WIDTH      = 2**LOG2_WIDTH,
  parameter int NUM_REQ    = 4,
  parameter int ID_W       = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*WIDTH-1:0] req_operand,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic [WIDTH-1:0]         blc_operand,
  output logic [LOG2_WIDTH-1:0]    blc_k,
  input  logic [WIDTH-2:0]         blc_log_formt,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [LOG2_WIDTH-1:0]    out_k,
  output logic [WIDTH-2:0]         out_frac,
  output logic                     out_zero,
  output logic [ID_W-1:0]          out_id,
  output logic                     busy
);

  logic                  s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0]      s1_op_q, s1_op_d;
  logic [ID_W-1:0]       s1_id_q, s1_id_d;
  logic [ID_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic                  out_valid_q, out_valid_d;
  logic [LOG2_WIDTH-1:0] out_k_q, out_k_d;
  logic [WIDTH-2:0]      out_frac_q, out_frac_d;
  logic                  out_zero_q, out_zero_d;
  logic [ID_W-1:0]       out_id_q, out_id_d;

  logic                  s2_adv, s1_adv;
  logic                  grant_found;
  logic [ID_W-1:0]       grant_idx;
  logic [ID_W:0]         cand;
  logic [LOG2_WIDTH-1:0] s1_k;
  logic                  s1_zero;

  // Round-robin search starts just after the last granted requester.
  always_comb begin
    s2_adv      = !out_valid_q || out_ready;
    s1_adv      = !s1_valid_q || s2_adv;
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    if (s1_adv && !flush && rst_n) begin
      for (int off = 1; off <= NUM_REQ; off++) begin
        cand = {1'b0, rr_ptr_q} + (ID_W+1)'(off);
        if (cand >= (ID_W+1)'(NUM_REQ)) cand = cand - (ID_W+1)'(NUM_REQ);
        if (!grant_found && req_valid[cand[ID_W-1:0]]) begin
          grant_found = 1'b1;
          grant_idx   = cand[ID_W-1:0];
        end
      end
    end
    req_ready = grant_found ? (NUM_REQ'(1) << grant_idx) : '0;
  end

  always_comb begin
    s1_k    = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (s1_op_q[i]) s1_k = LOG2_WIDTH'(i);
    end
    s1_zero     = (s1_op_q == '0);
    blc_operand = s1_valid_q ? s1_op_q : '0;
    blc_k       = s1_valid_q ? s1_k : '0;
  end

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_op_d     = s1_op_q;
    s1_id_d     = s1_id_q;
    rr_ptr_d    = rr_ptr_q;
    out_valid_d = out_valid_q;
    out_k_d     = out_k_q;
    out_frac_d  = out_frac_q;
    out_zero_d  = out_zero_q;
    out_id_d    = out_id_q;
    if (flush) begin
      s1_valid_d  = 1'b0;
      out_valid_d = 1'b0;
    end else begin
      if (s2_adv) begin
        out_valid_d = s1_valid_q;
        if (s1_valid_q) begin
          out_k_d    = s1_zero ? '0 : s1_k;
          out_frac_d = s1_zero ? '0 : blc_log_formt;
          out_zero_d = s1_zero;
          out_id_d   = s1_id_q;
        end
      end
      if (s1_adv) begin
        s1_valid_d = grant_found;
        if (grant_found) begin
          s1_op_d  = req_operand[int'(grant_idx)*WIDTH +: WIDTH];
          s1_id_d  = grant_idx;
          rr_ptr_d = grant_idx;
        end
      end
    end
  end

  // Pointer resets to the last index so requester 0 wins the first arbitration.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_op_q     <= '0;
      s1_id_q     <= '0;
      rr_ptr_q    <= ID_W'(NUM_REQ-1);
      out_valid_q <= 1'b0;
      out_k_q     <= '0;
      out_frac_q  <= '0;
      out_zero_q  <= 1'b0;
      out_id_q    <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_op_q     <= s1_op_d;
      s1_id_q     <= s1_id_d;
      rr_ptr_q    <= rr_ptr_d;
      out_valid_q <= out_valid_d;
      out_k_q     <= out_k_d;
      out_frac_q  <= out_frac_d;
      out_zero_q  <= out_zero_d;
      out_id_q    <= out_id_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_k     = out_k_q;
  assign out_frac  = out_frac_q;
  assign out_zero  = out_zero_q;
  assign out_id    = out_id_q;
  assign busy      = s1_valid_q || out_valid_q;

endmodule

// File: tb/tb_blc_sched.sv
// Self-checking bench for blc_sched: transaction-queue reference model plus directed literal checks.
// Also stands in for the external BLC datapath (fraction from operand and K).
module tb_blc_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic [3:0]  req_valid;
  logic [63:0] req_operand;
  logic [3:0]  req_ready;
  logic [15:0] blc_operand;
  logic [3:0]  blc_k;
  logic [14:0] blc_log_formt;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_k;
  logic [14:0] out_frac;
  logic        out_zero;
  logic [1:0]  out_id;
  logic        busy;

  logic [3:0]  vld;
  logic [15:0] ops [4];

  typedef struct {
    logic [15:0] op;
    int          id;
    int          stage;
  } item_t;

  item_t pipe[$];
  int    m_rr;
  int    n_checks = 0;
  int    n_fail = 0;

  always #5 clk = ~clk;

  assign req_valid   = vld;
  assign req_operand = {ops[3], ops[2], ops[1], ops[0]};

  blc_sched dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .req_valid(req_valid), .req_operand(req_operand), .req_ready(req_ready),
    .blc_operand(blc_operand), .blc_k(blc_k), .blc_log_formt(blc_log_formt),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_k(out_k), .out_frac(out_frac), .out_zero(out_zero), .out_id(out_id),
    .busy(busy)
  );

  // External BLC: bits below the leading one, left-aligned into the fraction.
  always_comb begin
    logic [31:0] t;
    t = 32'(blc_operand) << (15 - int'(blc_k));
    blc_log_formt = t[14:0];
  end

  function automatic int expK(int op);
    if (op == 0) return 0;
    return $clog2(op + 1) - 1;
  endfunction

  function automatic int expFrac(int op);
    int k;
    if (op == 0) return 0;
    k = expK(op);
    return ((op - (1 << k)) << (15 - k)) & 32'h7FFF;
  endfunction

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic bit modelOutValid();
    return pipe.size() > 0 && pipe[0].stage == 2;
  endfunction

  function automatic bit modelS1Full();
    return pipe.size() > 0 && pipe[pipe.size()-1].stage == 1;
  endfunction

  function automatic int modelGrant();
    bit s2a, s1a;
    s2a = !modelOutValid() || out_ready;
    s1a = !modelS1Full() || s2a;
    if (flush || !s1a || !rst_n) return -1;
    for (int off = 1; off <= 4; off++) begin
      int j;
      j = (m_rr + off) % 4;
      if (vld[j]) return j;
    end
    return -1;
  endfunction

  function automatic void modelAdvance(int g);
    item_t t;
    if (flush) begin
      pipe.delete();
      return;
    end
    if (modelOutValid() && out_ready) void'(pipe.pop_front());
    if (pipe.size() == 1 && pipe[0].stage == 1) begin
      t = pipe[0];
      t.stage = 2;
      pipe[0] = t;
    end
    if (g >= 0) begin
      t.op = ops[g];
      t.id = g;
      t.stage = 1;
      pipe.push_back(t);
      m_rr = g;
    end
  endfunction

  task automatic checkOutput();
    int g;
    int s1op;
    g = modelGrant();
    chk("req_ready", 32'(req_ready), (g >= 0) ? (32'd1 << g) : 32'd0);
    chk("out_valid", 32'(out_valid), 32'(modelOutValid()));
    chk("busy", 32'(busy), 32'(pipe.size() > 0));
    s1op = modelS1Full() ? int'(pipe[pipe.size()-1].op) : 0;
    chk("blc_operand", 32'(blc_operand), s1op);
    chk("blc_k", 32'(blc_k), expK(s1op));
    if (modelOutValid()) begin
      chk("out_k", 32'(out_k), expK(int'(pipe[0].op)));
      chk("out_frac", 32'(out_frac), expFrac(int'(pipe[0].op)));
      chk("out_zero", 32'(out_zero), 32'(pipe[0].op == 16'h0));
      chk("out_id", 32'(out_id), pipe[0].id);
    end
  endtask

  task automatic runCycle();
    int g;
    @(negedge clk);
    checkOutput();
    g = modelGrant();
    @(posedge clk);
    modelAdvance(g);
    #1;
    if (g >= 0) vld[g] = 1'b0;
  endtask

  function automatic logic [15:0] randOp();
    case ($urandom % 8)
      0: return 16'h0000;
      1: return 16'h0001;
      2: return 16'h8000;
      3: return 16'hFFFF;
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic applyStimulus();
    for (int i = 0; i < 4; i++) begin
      if (!vld[i] && ($urandom % 3 == 0)) begin
        vld[i] = 1'b1;
        ops[i] = randOp();
      end
    end
    out_ready = ($urandom % 4) != 0;
    flush     = ($urandom % 32) == 0;
  endtask

  task automatic directedOne(int id, logic [15:0] op, int ek, int ef, int ez);
    vld[id] = 1'b1;
    ops[id] = op;
    runCycle();
    chk("single_lat1_valid", 32'(out_valid), 0);
    runCycle();
    chk("single_valid", 32'(out_valid), 1);
    chk("single_k", 32'(out_k), ek);
    chk("single_frac", 32'(out_frac), ef);
    chk("single_zero", 32'(out_zero), ez);
    chk("single_id", 32'(out_id), id);
    runCycle();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    flush = 1'b0;
    out_ready = 1'b1;
    vld = 4'hF;
    for (int i = 0; i < 4; i++) ops[i] = 16'(i + 1);
    pipe.delete();
    m_rr = 3;
    #3;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_req_ready", 32'(req_ready), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_blc_operand", 32'(blc_operand), 0);
    chk("rst_out_k", 32'(out_k), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // All four continuously requesting: rotation 0,1,2,3,...
    for (int c = 0; c < 10; c++) begin
      for (int i = 0; i < 4; i++) if (!vld[i]) ops[i] = randOp();
      vld = 4'hF;
      #1;
      chk("rr_grant", 32'(req_ready), 32'd1 << (c % 4));
      if (c >= 2) begin
        chk("rr_out_valid", 32'(out_valid), 1);
        chk("rr_out_id", 32'(out_id), (c - 2) % 4);
      end
      runCycle();
    end
    vld = 4'h0;
    for (int c = 0; c < 3; c++) runCycle();

    directedOne(2, 16'h00A0, 7, 16'h2000, 0);
    directedOne(0, 16'h8000, 15, 16'h0000, 0);
    directedOne(0, 16'hFFFF, 15, 16'h7FFF, 0);
    directedOne(0, 16'h0001, 0, 16'h0000, 0);
    directedOne(0, 16'h0000, 0, 16'h0000, 1);

    // Backpressure with three pending requests.
    out_ready = 1'b0;
    vld = 4'b0111;
    ops[0] = 16'h1234; ops[1] = 16'h0F00; ops[2] = 16'h0003;
    for (int c = 0; c < 5; c++) begin
      runCycle();
      if (c >= 1) chk("stall_req_ready", 32'(req_ready), 0);
    end
    out_ready = 1'b1;
    for (int c = 0; c < 6; c++) runCycle();

    // Flush with both stages full.
    out_ready = 1'b0;
    vld = 4'b0011;
    ops[0] = 16'h0400; ops[1] = 16'h7001;
    runCycle();
    runCycle();
    chk("flush_pre_busy", 32'(busy), 1);
    vld = 4'hF;
    flush = 1'b1;
    #1;
    chk("flush_req_ready", 32'(req_ready), 0);
    runCycle();
    flush = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("flush_out_valid", 32'(out_valid), 0);
    chk("flush_busy", 32'(busy), 0);
    for (int c = 0; c < 4; c++) runCycle();
    vld = 4'h0;
    for (int c = 0; c < 3; c++) runCycle();

    for (int c = 0; c < 1500; c++) begin
      applyStimulus();
      runCycle();
    end

    // Asynchronous reset mid-stream.
    flush = 1'b0;
    out_ready = 1'b1;
    vld = 4'hF;
    runCycle();
    vld = 4'hF;
    runCycle();
    #1 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 32'(out_valid), 0);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_out_k", 32'(out_k), 0);
    chk("arst_out_frac", 32'(out_frac), 0);
    chk("arst_out_id", 32'(out_id), 0);
    chk("arst_blc_operand", 32'(blc_operand), 0);
    chk("arst_blc_k", 32'(blc_k), 0);
    chk("arst_req_ready", 32'(req_ready), 0);
    pipe.delete();
    m_rr = 3;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    vld = 4'hF;
    #1;
    chk("post_rst_grant", 32'(req_ready), 32'h1);
    for (int c = 0; c < 300; c++) begin
      applyStimulus();
      runCycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
